// File: rtl/freq_bank_if.sv
// Configuration write port for freq_bank: one (lo, hi) pair per transfer,
// addressed to a single channel, with a valid/ready handshake.
interface freq_bank_if #(
    parameter int N_CNT = 8,
    parameter int CH_W  = 2
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [N_CNT-1:0] cfg_lo;
    logic [N_CNT-1:0] cfg_hi;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_lo,
        output cfg_hi,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_lo,
        input  cfg_hi,
        output cfg_ready
    );
endinterface

// File: rtl/freq_bank.sv
// Multi-channel programmable square-wave generator. Each channel alternates
// an INIT phase of lo+1 cycles and an opposite phase of hi+1 cycles. New
// (lo, hi) pairs are held pending and swapped in only at a period boundary
// (wrap, disable or sync), so the waveform never glitches mid-period.
module freq_bank #(
    parameter int               N_CH   = 4,
    parameter int               N_CNT  = 8,
    parameter int               CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter logic             INIT   = 1'b0,
    parameter logic [N_CNT-1:0] DEF_LO = '0,
    parameter logic [N_CNT-1:0] DEF_HI = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] en,
    input  logic            sync,
    freq_bank_if.slave      cfg,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] wrap
);

    logic [N_CH-1:0][N_CNT-1:0] lo_q, lo_d;
    logic [N_CH-1:0][N_CNT-1:0] hi_q, hi_d;
    logic [N_CH-1:0][N_CNT-1:0] p_lo_q, p_lo_d;
    logic [N_CH-1:0][N_CNT-1:0] p_hi_q, p_hi_d;
    logic [N_CH-1:0][N_CNT-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]            pend_q, pend_d;
    logic [N_CH-1:0]            ph_q, ph_d;

    logic cfg_ready_c;
    logic accept;

    // Ready reflects the addressed channel's pending slot; unmapped indices never match.
    always_comb begin
        cfg_ready_c = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                cfg_ready_c = ~pend_q[i];
            end
        end
    end

    assign cfg.cfg_ready = cfg_ready_c;
    assign accept        = cfg.cfg_valid & cfg_ready_c;
    assign out           = ph_q;

    // Per-channel phase counting, boundary detection and config swap-in.
    always_comb begin
        logic [N_CNT-1:0] len;
        logic             term;
        logic             wr;
        logic             restart;

        lo_d    = lo_q;
        hi_d    = hi_q;
        p_lo_d  = p_lo_q;
        p_hi_d  = p_hi_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ph_d    = ph_q;
        wrap    = '0;
        len     = '0;
        term    = 1'b0;
        wr      = 1'b0;
        restart = 1'b0;

        for (int i = 0; i < N_CH; i++) begin
            len     = (ph_q[i] == INIT) ? lo_q[i] : hi_q[i];
            term    = (cnt_q[i] == len);
            wr      = en[i] & (ph_q[i] != INIT) & term;
            restart = sync | ~en[i];
            wrap[i] = wr;

            if ((restart | wr) & pend_q[i]) begin
                lo_d[i]   = p_lo_q[i];
                hi_d[i]   = p_hi_q[i];
                pend_d[i] = 1'b0;
            end

            if (restart) begin
                ph_d[i]  = INIT;
                cnt_d[i] = '0;
            end else if (term) begin
                ph_d[i]  = ~ph_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            // An accept implies pend_q was clear, so it never collides with the swap above.
            if (accept && (cfg.cfg_ch == CH_W'(i))) begin
                p_lo_d[i] = cfg.cfg_lo;
                p_hi_d[i] = cfg.cfg_hi;
                pend_d[i] = 1'b1;
            end
        end
    end

    // State registers; reset discards pending writes and restores default timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= {N_CH{DEF_LO}};
            hi_q   <= {N_CH{DEF_HI}};
            p_lo_q <= '0;
            p_hi_q <= '0;
            cnt_q  <= '0;
            pend_q <= '0;
            ph_q   <= {N_CH{INIT}};
        end else begin
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            p_lo_q <= p_lo_d;
            p_hi_q <= p_hi_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ph_q   <= ph_d;
        end
    end

endmodule

// File: tb/tb_freq_bank.sv
// Testbench for freq_bank (N_CH=4, N_CNT=4, INIT=0, DEF_LO=1, DEF_HI=0).
// A position-in-period model predicts out/wrap/cfg_ready each cycle; the
// predictions are queued when stimulus is driven and checked at negedge.
module tb_freq_bank;

    localparam int N_CH  = 4;
    localparam int N_CNT = 4;
    localparam int CH_W  = 2;
    localparam int DLO   = 1;
    localparam int DHI   = 0;

    typedef struct {
        logic [N_CH-1:0] out;
        logic [N_CH-1:0] wrap;
        logic            ready;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] en;
    logic            sync;
    logic [N_CH-1:0] dut_out;
    logic [N_CH-1:0] dut_wrap;

    freq_bank_if #(.N_CNT(N_CNT), .CH_W(CH_W)) bus ();

    freq_bank #(
        .N_CH(N_CH), .N_CNT(N_CNT), .CH_W(CH_W), .INIT(1'b0),
        .DEF_LO(4'd1), .DEF_HI(4'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
        .cfg(bus.slave), .out(dut_out), .wrap(dut_wrap)
    );

    int n_cmp = 0;
    int n_err = 0;

    exp_t sb[$];

    int m_lo[N_CH], m_hi[N_CH], m_plo[N_CH], m_phi[N_CH], m_pos[N_CH];
    bit m_pend[N_CH];

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N_CH; i++) begin
            m_lo[i]   = DLO;
            m_hi[i]   = DHI;
            m_plo[i]  = 0;
            m_phi[i]  = 0;
            m_pos[i]  = 0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Predict this cycle, queue it, advance the model, then step one clock.
    task automatic applyStimulus(input int n);
        exp_t e;
        bit   acc;
        bit   restart;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                e.out[i]  = (m_pos[i] > m_lo[i]);
                e.wrap[i] = en[i] && (m_pos[i] == m_lo[i] + m_hi[i] + 1);
            end
            e.ready = !m_pend[bus.cfg_ch];
            sb.push_back(e);
            acc = bus.cfg_valid && e.ready;
            for (int i = 0; i < N_CH; i++) begin
                restart = sync || !en[i];
                if ((restart || e.wrap[i]) && m_pend[i]) begin
                    m_lo[i]   = m_plo[i];
                    m_hi[i]   = m_phi[i];
                    m_pend[i] = 1'b0;
                end
                if (restart || e.wrap[i]) m_pos[i] = 0;
                else                      m_pos[i] = m_pos[i] + 1;
                if (acc && (int'(bus.cfg_ch) == i)) begin
                    m_plo[i]  = int'(bus.cfg_lo);
                    m_phi[i]  = int'(bus.cfg_hi);
                    m_pend[i] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (acc) bus.cfg_valid = 1'b0;
        end
    endtask

    // Hold a write until accepted; reports the number of cycles it took.
    task automatic writeCfg(input int ch, input int lo, input int hi, output int cycles);
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_lo    = N_CNT'(lo);
        bus.cfg_hi    = N_CNT'(hi);
        bus.cfg_valid = 1'b1;
        cycles = 0;
        while (bus.cfg_valid && cycles < 40) begin
            applyStimulus(1);
            cycles++;
        end
        if (bus.cfg_valid) begin
            checkOutput("wr_timeout", 32'd0, 32'd1);
            bus.cfg_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor: compare queued predictions away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("sb_out",   32'(dut_out),       32'(e.out));
            checkOutput("sb_wrap",  32'(dut_wrap),      32'(e.wrap));
            checkOutput("sb_ready", 32'(bus.cfg_ready), 32'(e.ready));
        end
    end

    // Directed sequence following the test plan
    initial begin
        int          cyc;
        logic [9:0]  r1o, r1w;
        logic [7:0]  r2o, r2w;
        logic [17:0] r3o;
        logic [6:0]  r3r;
        logic [3:0]  r4a, r4b;
        logic [5:0]  r5o;
        logic [2:0]  r6r;

        rst_n         = 1'b0;
        en            = '0;
        sync          = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_lo    = '0;
        bus.cfg_hi    = '0;
        modelReset();
        #3;
        checkOutput("rst_out",   32'(dut_out),       32'd0);
        checkOutput("rst_wrap",  32'(dut_wrap),      32'd0);
        checkOutput("rst_ready", 32'(bus.cfg_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(2);

        // 1: ch0 (1,2) -> 0,0,1,1,1 with wrap on the third high cycle
        writeCfg(0, 1, 2, cyc);
        applyStimulus(1);
        en = 4'b0001;
        r1o = '0; r1w = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            r1o = {r1o[8:0], dut_out[0]};
            r1w = {r1w[8:0], dut_wrap[0]};
            applyStimulus(1);
        end
        checkOutput("t1_out_seq",  32'(r1o), 32'b0011100111);
        checkOutput("t1_wrap_seq", 32'(r1w), 32'b0000100001);

        // 2: ch1 (0,0) toggles every cycle
        writeCfg(1, 0, 0, cyc);
        applyStimulus(1);
        en = 4'b0011;
        r2o = '0; r2w = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            r2o = {r2o[6:0], dut_out[1]};
            r2w = {r2w[6:0], dut_wrap[1]};
            applyStimulus(1);
        end
        checkOutput("t2_out_seq",  32'(r2o), 32'b01010101);
        checkOutput("t2_wrap_seq", 32'(r2w), 32'b01010101);

        // 3: restart ch0, write (3,3) in the second cycle of the period
        en = 4'b0010;
        applyStimulus(1);
        en = 4'b0011;
        bus.cfg_ch = 2'd0;
        bus.cfg_lo = 4'd3;
        bus.cfg_hi = 4'd3;
        r3o = '0; r3r = '0;
        for (int k = 0; k < 18; k++) begin
            if (k == 1) bus.cfg_valid = 1'b1;
            #1;
            r3o = {r3o[16:0], dut_out[0]};
            if (k < 7) r3r = {r3r[5:0], bus.cfg_ready};
            applyStimulus(1);
        end
        checkOutput("t3_out_seq",   32'(r3o), 32'b001110000111100001);
        checkOutput("t3_ready_seq", 32'(r3r), 32'b1100011);
        writeCfg(0, 1, 2, cyc);
        checkOutput("t3_first_wr_cycles", 32'(cyc), 32'd1);
        writeCfg(0, 2, 2, cyc);
        checkOutput("t3_stall_cycles", 32'(cyc), 32'd3);

        // 4: ch0 (1,2), ch2 (2,5) staggered, held sync then a sync pulse
        writeCfg(0, 1, 2, cyc);
        writeCfg(2, 2, 5, cyc);
        applyStimulus(3);
        en = 4'b0111;
        applyStimulus(7);
        sync = 1'b1;
        applyStimulus(3);
        sync = 1'b0;
        applyStimulus(6);
        sync = 1'b1;
        applyStimulus(1);
        sync = 1'b0;
        r4a = '0; r4b = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            r4a = {r4a[2:0], dut_out[0]};
            r4b = {r4b[2:0], dut_out[2]};
            applyStimulus(1);
        end
        checkOutput("t4_ch0_seq", 32'(r4a), 32'b0011);
        checkOutput("t4_ch2_seq", 32'(r4b), 32'b0001);

        // 5: pend a write to ch2, then reset during its high phase
        bus.cfg_ch    = 2'd2;
        bus.cfg_lo    = 4'd7;
        bus.cfg_hi    = 4'd7;
        bus.cfg_valid = 1'b1;
        applyStimulus(1);
        #1;
        checkOutput("t5_pre_high",  32'(dut_out[2]),    32'd1);
        checkOutput("t5_pre_ready", 32'(bus.cfg_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_out",   32'(dut_out),       32'd0);
        checkOutput("t5_async_wrap",  32'(dut_wrap),      32'd0);
        checkOutput("t5_async_ready", 32'(bus.cfg_ready), 32'd1);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r5o = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            r5o = {r5o[4:0], dut_out[0]};
            applyStimulus(1);
        end
        checkOutput("t5_default_seq", 32'(r5o), 32'b001001);

        // 6: write to disabled ch3 applies on the next edge
        bus.cfg_ch    = 2'd3;
        bus.cfg_lo    = 4'd4;
        bus.cfg_hi    = 4'd4;
        bus.cfg_valid = 1'b1;
        r6r = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            r6r = {r6r[1:0], bus.cfg_ready};
            applyStimulus(1);
        end
        checkOutput("t6_ready_seq", 32'(r6r), 32'b101);
        applyStimulus(4);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
